// File: rtl/output_port_monitor.sv
// Change-logging capture block for the CPU output port: every change of out_word
// is queued into a small FIFO that a host drains through a valid/ready handshake.
module output_port_monitor #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        out_word,
  input  logic                     capture_en,
  output logic [DATA_W-1:0]        host_data,
  output logic                     host_valid,
  input  logic                     host_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  input  logic                     clear_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] prev;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [CNT_W-1:0]  count;
  logic              overflow_q;

  logic change;
  logic push_req;
  logic pop;
  logic full;
  logic push;
  logic drop;

  always_comb begin
    change   = (out_word != prev);
    push_req = capture_en & change;
    pop      = host_valid & host_ready;
    full     = (count == CNT_FULL);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    push     = push_req & (~full | pop);
    drop     = push_req & full & ~pop;
  end

  // Control state: pointers, occupancy, sticky overflow and the change reference.
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev       <= '0;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      prev <= out_word;
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      // A drop wins over a simultaneous clear so no lost word goes unreported.
      if (drop)
        overflow_q <= 1'b1;
      else if (clear_overflow)
        overflow_q <= 1'b0;
    end
  end

  // Payload storage carries no reset; stale entries are never visible past count.
  always_ff @(posedge clk) begin
    if (reset && push)
      mem[wptr] <= out_word;
  end

  always_comb begin
    host_valid = (count != '0);
    host_data  = host_valid ? mem[rptr] : '0;
    fifo_count = count;
    overflow   = overflow_q;
  end

endmodule

// File: tb/tb_output_port_monitor.sv
// Scoreboard bench for output_port_monitor: stimulus queues expected words, a
// negedge monitor compares every word the host accepts.
module tb_output_port_monitor;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] out_word;
  logic              capture_en;
  logic [DATA_W-1:0] host_data;
  logic              host_valid;
  logic              host_ready;
  logic [2:0]        fifo_count;
  logic              overflow;
  logic              clear_overflow;

  int n_vec = 0;
  int n_bad = 0;
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] mon_exp;

  output_port_monitor #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .out_word       (out_word),
    .capture_en     (capture_en),
    .host_data      (host_data),
    .host_valid     (host_valid),
    .host_ready     (host_ready),
    .fifo_count     (fifo_count),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [DATA_W-1:0] v);
    out_word = v;
    step();
  endtask

  task automatic drain(input int n);
    host_ready = 1'b1;
    repeat (n) step();
    host_ready = 1'b0;
  endtask

  // Every word the host takes must be the oldest outstanding expected word.
  always @(negedge clk) begin
    if (reset && host_valid && host_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_word: got %0h expected none", host_data);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("drain_data", 32'(host_data), 32'(mon_exp));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b0;
    out_word       = 16'hf0f0;
    capture_en     = 1'b1;
    host_ready     = 1'b0;
    clear_overflow = 1'b0;

    // Reset and idle
    repeat (2) begin
      step();
      chk("rst_valid", 32'(host_valid), 32'd0);
      chk("rst_data",  32'(host_data),  32'd0);
      chk("rst_count", 32'(fifo_count), 32'd0);
      chk("rst_ovf",   32'(overflow),   32'd0);
    end
    reset = 1'b1;
    exp_q.push_back(16'hf0f0);
    step();
    chk("first_count", 32'(fifo_count), 32'd1);
    chk("first_data",  32'(host_data),  32'hf0f0);
    step();
    chk("held_count",  32'(fifo_count), 32'd1);
    drain(1);
    chk("empty_count", 32'(fifo_count), 32'd0);
    chk("empty_data",  32'(host_data),  32'd0);

    // Change detection
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0002);
    exp_q.push_back(16'h0003);
    repeat (3) drive(16'h0001);
    drive(16'h0002);
    repeat (2) drive(16'h0003);
    chk("chg_count", 32'(fifo_count), 32'd3);
    drain(3);
    chk("chg_drained", 32'(fifo_count), 32'd0);

    // Capture gating
    capture_en = 1'b0;
    drive(16'h1111);
    drive(16'h2222);
    capture_en = 1'b1;
    drive(16'h2222);
    step();
    chk("gate_none", 32'(fifo_count), 32'd0);
    exp_q.push_back(16'h3333);
    drive(16'h3333);
    chk("gate_one", 32'(fifo_count), 32'd1);
    drain(1);

    // Overflow, then clear
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(16'ha000 + 16'(i));
      drive(16'ha000 + 16'(i));
    end
    chk("ovf_count", 32'(fifo_count), 32'd4);
    chk("ovf_set",   32'(overflow),   32'd1);
    drain(4);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    chk("ovf_clear", 32'(overflow), 32'd0);

    // Drop coinciding with clear: set wins
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(16'hb000 + 16'(i));
      drive(16'hb000 + 16'(i));
    end
    clear_overflow = 1'b1;
    drive(16'hb005);
    clear_overflow = 1'b0;
    chk("ovf_setwins", 32'(overflow),   32'd1);
    chk("ovf_full",    32'(fifo_count), 32'd4);
    drain(4);
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    chk("ovf_clear2", 32'(overflow), 32'd0);

    // Full with simultaneous push and pop, across pointer wrap
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(16'hc000 + 16'(i));
      drive(16'hc000 + 16'(i));
    end
    host_ready = 1'b1;
    for (int i = 5; i <= 14; i++) begin
      exp_q.push_back(16'hc000 + 16'(i));
      drive(16'hc000 + 16'(i));
      chk("stream_count", 32'(fifo_count), 32'd4);
      chk("stream_ovf",   32'(overflow),   32'd0);
    end
    drain(4);
    chk("stream_drained", 32'(fifo_count), 32'd0);

    // Reset mid-stream with 3 entries held and overflow set
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(16'hd000 + 16'(i));
      drive(16'hd000 + 16'(i));
    end
    drain(1);
    chk("mid_count", 32'(fifo_count), 32'd3);
    chk("mid_ovf",   32'(overflow),   32'd1);
    reset    = 1'b0;
    out_word = 16'h0000;
    step();
    exp_q.delete();
    chk("mid_rst_count", 32'(fifo_count), 32'd0);
    chk("mid_rst_valid", 32'(host_valid), 32'd0);
    chk("mid_rst_ovf",   32'(overflow),   32'd0);
    chk("mid_rst_data",  32'(host_data),  32'd0);
    reset = 1'b1;
    step();
    step();
    chk("zero_not_logged", 32'(fifo_count), 32'd0);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
